// File: rtl/timer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : timer                                                        |
// | Description : One-shot pulse timer. A rising edge on TRG_ONE drives OUT    |
// |               high for exactly N clock cycles. MODE=0 ignores triggers     |
// |               while a pulse runs; MODE=1 restarts the count on a trigger.  |
// | Ports       : CLK     in  system clock, rising edge                        |
// |               R       in  asynchronous reset, active-low                   |
// |               TRG_ONE in  trigger level; only a 0->1 transition fires      |
// |               MODE    in  0 = non-retriggerable, 1 = retriggerable         |
// |               OUT     out registered pulse output                          |
// | Options     : TIMER_TRG_SYNC_EN - adds a 2-flop synchronizer on TRG_ONE    |
// |               (trigger-to-OUT latency 3 cycles instead of 1)               |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module timer #(
  parameter int N     = 16,
  parameter int CNT_W = $clog2(N + 1)
) (
  input  logic CLK,
  input  logic R,
  input  logic TRG_ONE,
  input  logic MODE,
  output logic OUT
);

  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(N - 1);
  localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);

  logic             trg_src;
  logic             trg_q,    trg_d;
  logic             active_q, active_d;
  logic             out_q,    out_d;
  logic [CNT_W-1:0] count_q,  count_d;
  logic             trg_rise;

`ifdef TIMER_TRG_SYNC_EN
  // Both synchronizer stages reset to 1 so a trigger held high through
  // reset release is not mistaken for a fresh edge.
  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;

  always_comb begin
    sync1_d = TRG_ONE;
    sync2_d = sync1_q;
  end

  always_ff @(posedge CLK or negedge R) begin
    if (!R) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign trg_src = sync2_q;
`else
  assign trg_src = TRG_ONE;
`endif

  assign trg_rise = trg_src & ~trg_q;

  always_comb begin
    trg_d    = trg_src;
    active_d = active_q;
    out_d    = out_q;
    count_d  = count_q;
    if (!active_q) begin
      if (trg_rise) begin
        active_d = 1'b1;
        out_d    = 1'b1;
        count_d  = '0;
      end
    end else if (trg_rise && MODE) begin
      // Retrigger takes priority over the terminal compare, so a trigger on
      // the last cycle extends the pulse with no gap.
      count_d = '0;
    end else if (count_q == C_LAST) begin
      active_d = 1'b0;
      out_d    = 1'b0;
      count_d  = '0;
    end else begin
      count_d = count_q + C_ONE;
    end
  end

  // trg_q resets to 1: a level already high at reset release must not fire.
  always_ff @(posedge CLK or negedge R) begin
    if (!R) begin
      trg_q    <= 1'b1;
      active_q <= 1'b0;
      out_q    <= 1'b0;
      count_q  <= '0;
    end else begin
      trg_q    <= trg_d;
      active_q <= active_d;
      out_q    <= out_d;
      count_q  <= count_d;
    end
  end

  assign OUT = out_q;

endmodule
`default_nettype wire

// File: tb/tb_timer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_timer                                                     |
// | Description : Self-checking bench for timer (N=16). Table of pulse         |
// |               scenarios plus hand-written reset sequences; expected OUT    |
// |               values are queued as stimulus is driven and compared after   |
// |               each clock edge.                                             |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_timer;

  localparam int N = 16;
`ifdef TIMER_TRG_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic CLK = 1'b0;
  logic R;
  logic TRG_ONE;
  logic MODE;
  logic OUT;

  int checks   = 0;
  int failures = 0;
  logic exp_q[$];

  timer #(.N(N)) dut (
    .CLK    (CLK),
    .R      (R),
    .TRG_ONE(TRG_ONE),
    .MODE   (MODE),
    .OUT    (OUT)
  );

  always #5 CLK = ~CLK;

  // One scenario: trigger pulses at steps e1/e2 (-1 = none), expected OUT
  // high for l1 steps from s1 and l2 steps from s2, run for len steps.
  typedef struct {
    logic mode;
    int   e1;
    int   e2;
    int   s1;
    int   l1;
    int   s2;
    int   l2;
    int   len;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: OUT=%0b expected %0b", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, queue the OUT expected after the next edge,
  // then compare once the edge has been taken.
  task automatic step(input string name, input logic trg, input logic mode,
                      input logic rst_n, input logic exp);
    logic e;
    TRG_ONE = trg;
    MODE    = mode;
    R       = rst_n;
    exp_q.push_back(exp);
    @(posedge CLK);
    #1;
    e = exp_q.pop_front();
    check(name, OUT, e);
  endtask

  task automatic run_vec(input int idx);
    vec_t v;
    logic trg;
    logic exp;
    v = vecs[idx];
    for (int i = 0; i < v.len + LAT; i++) begin
      trg = (i == v.e1) || (i == v.e2);
      exp = ((i >= v.s1 + LAT) && (i < v.s1 + LAT + v.l1)) ||
            ((i >= v.s2 + LAT) && (i < v.s2 + LAT + v.l2));
      step($sformatf("vec%0d step%0d", idx, i), trg, v.mode, 1'b1, exp);
    end
  endtask

  initial begin
    //               mode  e1  e2  s1  l1  s2  l2 len
    vecs[0] = '{1'b0,  2, -1,  2, 16,  0,  0, 24}; // single pulse, 16 wide
    vecs[1] = '{1'b0,  2,  7,  2, 16,  0,  0, 24}; // retrigger ignored
    vecs[2] = '{1'b1,  2, 12,  2, 26,  0,  0, 36}; // retrigger +10 -> 26
    vecs[3] = '{1'b1,  2, 18,  2, 32,  0,  0, 40}; // retrigger on terminal
    vecs[4] = '{1'b0,  2, 18,  2, 16,  0,  0, 24}; // terminal trigger ignored
    vecs[5] = '{1'b0,  2, 19,  2, 16, 19, 16, 40}; // new pulse after fall
    vecs[6] = '{1'b1,  2, -1,  2, 16,  0,  0, 24}; // MODE=1 single pulse
    vecs[7] = '{1'b1,  2,  4,  2, 18,  0,  0, 26}; // early retrigger

    // Reset held with the trigger high through release: no pulse.
    R       = 1'b0;
    TRG_ONE = 1'b1;
    MODE    = 1'b0;
    #1;
    check("reset_async", OUT, 1'b0);
    step("reset0", 1'b1, 1'b0, 1'b0, 1'b0);
    step("reset1", 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++)
      step($sformatf("held_trg%0d", i), 1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++)
      step($sformatf("idle%0d", i), 1'b0, 1'b0, 1'b1, 1'b0);

    for (int k = 0; k < 8; k++)
      run_vec(k);

    // Reset four cycles into a pulse drops OUT without waiting for a clock.
    step("midrst_idle", 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4 + LAT; i++)
      step($sformatf("midrst_pulse%0d", i), (i == 0), 1'b0, 1'b1, (i >= LAT));
    R = 1'b0;
    #1;
    check("midrst_async", OUT, 1'b0);
    step("midrst_hold0", 1'b0, 1'b0, 1'b0, 1'b0);
    step("midrst_hold1", 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)
      step($sformatf("midrst_rel%0d", i), 1'b0, 1'b0, 1'b1, 1'b0);
    run_vec(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Safety net against a stalled simulation.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
